// File: rtl/mul_div_sequencer_pkg.sv
// Shared types for the iterative multiply/divide sequencer: op codes, FSM states
// and the default iteration count.
package mul_div_sequencer_pkg;

  localparam int unsigned MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_OP_MULU = 2'd0,
    MD_OP_MULS = 2'd1,
    MD_OP_DIVU = 2'd2,
    MD_OP_DIVS = 2'd3
  } md_op_e;

  typedef enum logic [2:0] {
    MD_ST_IDLE = 3'd0,
    MD_ST_PREP = 3'd1,
    MD_ST_RUN  = 3'd2,
    MD_ST_FIX  = 3'd3,
    MD_ST_DONE = 3'd4
  } md_state_e;

  function automatic logic op_is_div(input md_op_e o);
    return (o == MD_OP_DIVU) || (o == MD_OP_DIVS);
  endfunction

  function automatic logic op_is_signed(input md_op_e o);
    return (o == MD_OP_MULS) || (o == MD_OP_DIVS);
  endfunction

endpackage

// File: rtl/mul_div_sequencer_units.sv
// Arithmetic primitives used by the sequencer: a carry-in/carry-out adder and
// an incrementer used for two's-complement negation of inverted values.
module AdderUnit #(
  parameter int unsigned N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         in_c,
  output logic [N-1:0] sum,
  output logic         out_c
);
  assign {out_c, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, in_c};
endmodule

module IncrementerUnit #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);
  assign y = a + {{(N-1){1'b0}}, 1'b1};
endmodule

// File: rtl/mul_div_sequencer.sv
// Iterative multiply (radix-2 shift-add) / divide (restoring) sequencer built
// around one shared (WIDTH+1)-bit adder, with abort and a one-cycle done pulse.
module mul_div_sequencer
  import mul_div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = MD_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero,
  output logic             ovl
);

  localparam int unsigned CW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, opd_q, opd_d, acc_q, acc_d, mpl_q, mpl_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             ovl_pend_q, ovl_pend_d, div_zero_q, div_zero_d, ovl_q, ovl_d;

  logic             is_div, is_sgn, dvs_zero;
  logic [WIDTH-1:0] abs_a, abs_b, quo_neg, rem_neg;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH:0]   add_a, add_b, add_s;
  logic             add_c, add_co;

  assign is_div   = op_is_div(op_q);
  assign is_sgn   = op_is_signed(op_q);
  assign dvs_zero = (opd_q == '0);
  assign abs_a    = (is_sgn && a_q[WIDTH-1])   ? ('0 - a_q)   : a_q;
  assign abs_b    = (is_sgn && opd_q[WIDTH-1]) ? ('0 - opd_q) : opd_q;

  // Divide trial-subtracts via inverted divisor + carry-in; carry out means no borrow.
  always_comb begin
    if (is_div) begin
      add_a = {acc_q, mpl_q[WIDTH-1]};
      add_b = ~{1'b0, opd_q};
      add_c = 1'b1;
    end else begin
      add_a = {1'b0, acc_q};
      add_b = mpl_q[0] ? {1'b0, opd_q} : '0;
      add_c = 1'b0;
    end
  end

  AdderUnit #(.N(WIDTH + 1)) u_add (
    .a(add_a), .b(add_b), .in_c(add_c), .sum(add_s), .out_c(add_co)
  );

  IncrementerUnit #(.N(2 * WIDTH)) u_inc_prod (.a(~{acc_q, mpl_q}), .y(prod_neg));
  IncrementerUnit #(.N(WIDTH))     u_inc_quo  (.a(~mpl_q),          .y(quo_neg));
  IncrementerUnit #(.N(WIDTH))     u_inc_rem  (.a(~acc_q),          .y(rem_neg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MD_ST_IDLE;
      op_q       <= MD_OP_MULU;
      a_q        <= '0;
      opd_q      <= '0;
      acc_q      <= '0;
      mpl_q      <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovl_pend_q <= 1'b0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      div_zero_q <= 1'b0;
      ovl_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      opd_q      <= opd_d;
      acc_q      <= acc_d;
      mpl_q      <= mpl_d;
      cnt_q      <= cnt_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      ovl_pend_q <= ovl_pend_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      div_zero_q <= div_zero_d;
      ovl_q      <= ovl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == MD_ST_IDLE) begin
      if (start && !abort) state_d = MD_ST_PREP;
    end else if (abort) begin
      state_d = MD_ST_IDLE;
    end else begin
      case (state_q)
        MD_ST_PREP: state_d = (is_div && dvs_zero) ? MD_ST_DONE : MD_ST_RUN;
        MD_ST_RUN:  if (cnt_q == '0) state_d = MD_ST_FIX;
        MD_ST_FIX:  state_d = MD_ST_DONE;
        MD_ST_DONE: state_d = MD_ST_IDLE;
        default:    state_d = MD_ST_IDLE;
      endcase
    end
  end

  // Result registers are written only on the edge that enters DONE.
  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    opd_d      = opd_q;
    acc_d      = acc_q;
    mpl_d      = mpl_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    ovl_pend_d = ovl_pend_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    div_zero_d = div_zero_q;
    ovl_d      = ovl_q;
    case (state_q)
      MD_ST_IDLE: begin
        if (start && !abort) begin
          op_d  = md_op_e'(op);
          a_d   = a;
          opd_d = b;
        end
      end
      MD_ST_PREP: begin
        acc_d      = '0;
        cnt_d      = CW'(WIDTH - 1);
        neg_res_d  = is_sgn && (a_q[WIDTH-1] ^ opd_q[WIDTH-1]);
        neg_rem_d  = is_sgn && a_q[WIDTH-1];
        ovl_pend_d = (op_q == MD_OP_DIVS) && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (opd_q == '1);
        mpl_d      = is_div ? abs_a : abs_b;
        opd_d      = is_div ? abs_b : abs_a;
        if (is_div && dvs_zero && !abort) begin
          res_hi_d   = a_q;
          res_lo_d   = '1;
          div_zero_d = 1'b1;
          ovl_d      = 1'b0;
        end
      end
      MD_ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div) begin
          if (add_co) begin
            acc_d = add_s[WIDTH-1:0];
            mpl_d = {mpl_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[WIDTH-2:0], mpl_q[WIDTH-1]};
            mpl_d = {mpl_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = add_s[WIDTH:1];
          mpl_d = {add_s[0], mpl_q[WIDTH-1:1]};
        end
      end
      MD_ST_FIX: begin
        if (!abort) begin
          if (is_div) begin
            res_lo_d = neg_res_q ? quo_neg : mpl_q;
            res_hi_d = neg_rem_q ? rem_neg : acc_q;
          end else begin
            {res_hi_d, res_lo_d} = neg_res_q ? prod_neg : {acc_q, mpl_q};
          end
          div_zero_d = 1'b0;
          ovl_d      = ovl_pend_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q != MD_ST_IDLE);
    done     = (state_q == MD_ST_DONE);
    res_hi   = res_hi_q;
    res_lo   = res_lo_q;
    div_zero = div_zero_q;
    ovl      = ovl_q;
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Scoreboard bench for mul_div_sequencer: stimulus pushes reference results,
// a monitor pops and compares them whenever done is seen.
module tb_mul_div_sequencer;

  logic        clk, rst_n, start, abort;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero, ovl;
  logic [31:0] res_hi, res_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        ov;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  mul_div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .busy(busy), .done(done), .res_hi(res_hi),
    .res_lo(res_lo), .div_zero(div_zero), .ovl(ovl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit / integer arithmetic straight from the op definitions.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    int          sx, sy;
    e.dz = 1'b0; e.ov = 1'b0; e.cyc = 0;
    sx = x; sy = y;
    case (o)
      2'd0: begin p = {32'd0, x} * {32'd0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin
        p = longint'(sx) * longint'(sy);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          e.dz = 1'b1; e.lo = 32'hFFFF_FFFF; e.hi = x;
        end else if (o == 2'd2) begin
          e.lo = x / y; e.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.ov = 1'b1; e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else begin
          e.lo = sx / sy; e.hi = sx % sy;
        end
      end
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("res_hi",   {32'd0, res_hi}, {32'd0, mon_e.hi});
        check("res_lo",   {32'd0, res_lo}, {32'd0, mon_e.lo});
        check("div_zero", {63'd0, div_zero}, {63'd0, mon_e.dz});
        check("ovl",      {63'd0, ovl}, {63'd0, mon_e.ov});
        check("latency",  64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic        busy_ok;
    int unsigned t;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    e = model(o, x, y);
    e.cyc = cyc + 1 + (e.dz ? 1 : 34);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    busy_ok = 1'b1; t = 0;
    while (sb.size() != 0 && t < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      t++;
    end
    check("busy_window", {63'd0, busy_ok}, 64'd1);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", t);
      sb.delete();
    end
    last_hi = e.hi; last_lo = e.lo;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
    #23;
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_done",  {63'd0, done}, 64'd0);
    check("rst_res",   {res_hi, res_lo}, 64'd0);
    check("rst_flags", {62'd0, div_zero, ovl}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd2, 32'd100, 32'd0);
    run_op(2'd3, 32'h8000_0000, 32'd0);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(2'd3, 32'd7, 32'hFFFF_FFFE);

    // Abort a DIVU at RUN iteration 10; no done and results must hold.
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("abort_hold", {res_hi, res_lo}, {last_hi, last_lo});
    run_op(2'd2, 32'd1000, 32'd7);

    for (int unsigned i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       ry = 32'd0;
        1:       ry = 32'hFFFF_FFFF;
        2:       ry = 32'($urandom_range(1, 15));
        default: ry = 32'($urandom);
      endcase
      run_op(ro, rx, ry);
    end

    // Reset mid-RUN, then start+abort together in IDLE.
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = $urandom; b = $urandom;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_out",  {res_hi, res_lo}, 64'd0);
    check("midrst_flag", {62'd0, div_zero, ovl}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; abort = 1'b1; op = 2'd2; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("post_rst_res", {res_hi, res_lo}, 64'd0);
    run_op(2'd1, 32'd12345, 32'hFFFF_FF00);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
